blowfish_feistel_engine: RTL and testbench



---
 rtl/bf_pkg.sv | 25 ++
 rtl/bf_addr_gen.sv | 70 +++++++
 rtl/blowfish_feistel_engine.sv | 124 ++++++++++++
 tb/tb_blowfish_feistel_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and helpers for the Blowfish Feistel engine.
package bf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RA,
    RB,
    RC,
    FIN,
    DONE
  } bf_state_t;

  localparam int unsigned S0_BASE = 0;
  localparam int unsigned S1_BASE = 256;
  localparam int unsigned S2_BASE = 512;
  localparam int unsigned S3_BASE = 768;

  // Second half of F: ((S0 + S1) ^ S2) + S3, with S0 + S1 already in f_r.
  function automatic logic [31:0] bf_f_combine(input logic [31:0] f_r,
                                               input logic [31:0] s2,
                                               input logic [31:0] s3);
    return (f_r ^ s2) + s3;
  endfunction

endpackage

// File: rtl/bf_addr_gen.sv
// Read address / chip-select generator for both table ports.
module bf_addr_gen
  import bf_pkg::*;
#(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned P_BASE = 1024,
  parameter int unsigned RND_W  = 4
) (
  input  bf_state_t         state,
  input  logic              accept,
  input  logic              decrypt_in,
  input  logic              decrypt_q,
  input  logic [RND_W-1:0]  rnd,
  input  logic [15:0]       lx_hi,
  input  logic [15:0]       l_lo,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              cs_a_l,
  output logic              cs_b_l
);

  int unsigned nxt;

  function automatic logic [ADDR_W-1:0] p_addr(input int unsigned idx);
    return ADDR_W'(P_BASE + idx);
  endfunction

  // Select the table word each state needs; idle cycles park at address 0.
  always_comb begin
    addr_a = '0;
    addr_b = '0;
    cs_a_l = 1'b1;
    cs_b_l = 1'b1;
    nxt    = 32'(rnd) + 1;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_a = p_addr(decrypt_in ? ROUNDS + 1 : 0);
          cs_a_l = 1'b0;
        end
      end
      RA: begin
        addr_a = ADDR_W'(S0_BASE + 32'(lx_hi[15:8]));
        addr_b = ADDR_W'(S1_BASE + 32'(lx_hi[7:0]));
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
      end
      RB: begin
        addr_a = ADDR_W'(S2_BASE + 32'(l_lo[15:8]));
        addr_b = ADDR_W'(S3_BASE + 32'(l_lo[7:0]));
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
      end
      RC: begin
        if (32'(rnd) < ROUNDS - 1) begin
          addr_a = p_addr(decrypt_q ? ROUNDS + 1 - nxt : nxt);
          cs_a_l = 1'b0;
        end else begin
          addr_a = p_addr(decrypt_q ? 0 : ROUNDS + 1);
          addr_b = p_addr(decrypt_q ? 1 : ROUNDS);
          cs_a_l = 1'b0;
          cs_b_l = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/blowfish_feistel_engine.sv
// Blowfish Feistel engine: 3 cycles per round, tables read via two SRAM ports.
module blowfish_feistel_engine
  import bf_pkg::*;
#(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned P_BASE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              decrypt,
  input  logic [31:0]       L_in,
  input  logic [31:0]       R_in,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              cs_a_l,
  output logic              cs_b_l,
  output logic              oe_a_l,
  output logic              oe_b_l,
  output logic              we_a_l,
  output logic              we_b_l,
  input  logic [31:0]       data_a,
  input  logic [31:0]       data_b,
  output logic [63:0]       result,
  output logic              done,
  output logic              busy
);

  localparam int unsigned RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  bf_state_t        state_q, state_d;
  logic [31:0]      l_q, r_q, f_q, lx;
  logic [RND_W-1:0] rnd_q;
  logic             dec_q;
  logic [63:0]      result_q;
  logic             accept;
  logic             last_round;

  assign accept     = (state_q == IDLE) && start && reset;
  assign last_round = (rnd_q == RND_W'(ROUNDS - 1));
  assign lx         = l_q ^ data_a;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RA;
      RA:      state_d = RB;
      RB:      state_d = RC;
      RC:      state_d = last_round ? FIN : RA;
      FIN:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: block halves, partial F, round counter and output block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      l_q      <= '0;
      r_q      <= '0;
      f_q      <= '0;
      rnd_q    <= '0;
      dec_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            l_q   <= L_in;
            r_q   <= R_in;
            dec_q <= decrypt;
            rnd_q <= '0;
          end
        end
        RA: l_q <= lx;
        RB: f_q <= data_a + data_b;
        RC: begin
          l_q <= r_q ^ bf_f_combine(f_q, data_a, data_b);
          r_q <= l_q;
          if (!last_round) rnd_q <= rnd_q + 1'b1;
        end
        // Halves are still swapped from the last round: R holds the true L.
        FIN: result_q <= {r_q ^ data_a, l_q ^ data_b};
        default: ;
      endcase
    end
  end

  bf_addr_gen #(
    .ROUNDS(ROUNDS),
    .ADDR_W(ADDR_W),
    .P_BASE(P_BASE),
    .RND_W (RND_W)
  ) u_addr_gen (
    .state     (state_q),
    .accept    (accept),
    .decrypt_in(decrypt),
    .decrypt_q (dec_q),
    .rnd       (rnd_q),
    .lx_hi     (lx[31:16]),
    .l_lo      (l_q[15:0]),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .cs_a_l    (cs_a_l),
    .cs_b_l    (cs_b_l)
  );

  assign oe_a_l = 1'b0;
  assign oe_b_l = 1'b0;
  assign we_a_l = 1'b1;
  assign we_b_l = 1'b1;
  assign result = result_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_blowfish_feistel_engine.sv
// Scoreboard bench: 16-round and 2-round engines sharing one dual-port table RAM.
module tb_blowfish_feistel_engine;

  localparam int unsigned PB = 1024;

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  logic        clk, reset;
  logic        start1, dec1, start2, dec2;
  logic [31:0] L1, R1, L2, R2;
  logic [11:0] addr_a1, addr_b1, addr_a2, addr_b2;
  logic        cs_a1, cs_b1, cs_a2, cs_b2;
  logic        oe_a1, oe_b1, oe_a2, oe_b2, we_a1, we_b1, we_a2, we_b2;
  logic [31:0] da1, db1, da2, db2;
  logic [63:0] result1, result2;
  logic        done1, done2, busy1, busy2;

  logic [31:0] mem [0:4095];
  exp_t        exp1[$];
  exp_t        exp2[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done1_cnt = 0;
  int          done2_cnt = 0;

  blowfish_feistel_engine #(.ROUNDS(16), .ADDR_W(12), .P_BASE(PB)) u_dut (
    .clk(clk), .reset(reset), .start(start1), .decrypt(dec1), .L_in(L1), .R_in(R1),
    .addr_a(addr_a1), .addr_b(addr_b1), .cs_a_l(cs_a1), .cs_b_l(cs_b1),
    .oe_a_l(oe_a1), .oe_b_l(oe_b1), .we_a_l(we_a1), .we_b_l(we_b1),
    .data_a(da1), .data_b(db1), .result(result1), .done(done1), .busy(busy1)
  );

  blowfish_feistel_engine #(.ROUNDS(2), .ADDR_W(12), .P_BASE(PB)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .decrypt(dec2), .L_in(L2), .R_in(R2),
    .addr_a(addr_a2), .addr_b(addr_b2), .cs_a_l(cs_a2), .cs_b_l(cs_b2),
    .oe_a_l(oe_a2), .oe_b_l(oe_b2), .we_a_l(we_a2), .we_b_l(we_b2),
    .data_a(da2), .data_b(db2), .result(result2), .done(done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data valid the cycle after a selected address.
  always @(posedge clk) begin
    if (!cs_a1) da1 <= mem[addr_a1];
    if (!cs_b1) db1 <= mem[addr_b1];
    if (!cs_a2) da2 <= mem[addr_a2];
    if (!cs_b2) db2 <= mem[addr_b2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: pop expected result whenever a DUT pulses done.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      done1_cnt++;
      if (exp1.size() == 0) chk("unexpected_done1", 64'd1, 64'd0);
      else begin
        e = exp1.pop_front();
        chk("result16", result1, e.val);
        chk("done_cycle16", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done16", 64'(busy1), 64'd1);
      end
    end
    if (done2 === 1'b1) begin
      done2_cnt++;
      if (exp2.size() == 0) chk("unexpected_done2", 64'd1, 64'd0);
      else begin
        e = exp2.pop_front();
        chk("result2r", result2, e.val);
        chk("done_cycle2r", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] f_ref(input logic [31:0] x);
    return ((mem[32'(x[31:24])] + mem[256 + 32'(x[23:16])]) ^ mem[512 + 32'(x[15:8])])
           + mem[768 + 32'(x[7:0])];
  endfunction

  // Textbook 16-round Blowfish over the bench table.
  function automatic logic [63:0] bf_ref(input logic [31:0] l_i, input logic [31:0] r_i,
                                         input logic dec);
    logic [31:0] l, r, t;
    l = l_i;
    r = r_i;
    for (int i = 0; i < 16; i++) begin
      l = l ^ mem[PB + (dec ? 17 - i : i)];
      r = r ^ f_ref(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ mem[PB + (dec ? 1 : 16)];
    l = l ^ mem[PB + (dec ? 0 : 17)];
    return {l, r};
  endfunction

  task automatic go1(input logic [31:0] l, input logic [31:0] r, input logic dec,
                     input logic [63:0] e);
    @(negedge clk);
    L1 = l; R1 = r; dec1 = dec; start1 = 1'b1;
    exp1.push_back('{e, cyc + 50});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic go2(input logic [31:0] l, input logic [31:0] r, input logic dec,
                     input logic [63:0] e);
    @(negedge clk);
    L2 = l; R2 = r; dec2 = dec; start2 = 1'b1;
    exp2.push_back('{e, cyc + 8});
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp1.size() != 0 || exp2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp1.size() != 0 || exp2.size() != 0) begin
      chk("drain_timeout", 64'(exp1.size() + exp2.size()), 64'd0);
      exp1.delete();
      exp2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    logic [63:0] e;
    logic [31:0] av;
    logic [31:0] vl [3];
    logic [31:0] vr [3];

    vl = '{32'h01234567, 32'hDEADBEEF, 32'hFFFFFFFF};
    vr = '{32'h89ABCDEF, 32'h00000000, 32'h12345678};
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    da1 = '0; db1 = '0; da2 = '0; db2 = '0;
    reset = 1'b0;
    start1 = 1'b0; dec1 = 1'b0; L1 = '0; R1 = '0;
    start2 = 1'b0; dec2 = 1'b0; L2 = '0; R2 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", result1, 64'd0);
    chk("rst_flags", {58'd0, done1, busy1, cs_a1, cs_b1, oe_a1, we_a1}, 64'b001101);
    chk("rst_addr", {40'd0, addr_a1, addr_b1}, 64'd0);
    reset = 1'b1;

    // Address trace, zero memory
    @(negedge clk);
    L1 = 32'h00010203; R1 = '0; dec1 = 1'b0; start1 = 1'b1;
    exp1.push_back('{64'h00000000_00010203, cyc + 50});
    #1 chk("trace_T", {49'd0, busy1, cs_a1, cs_b1, addr_a1}, {49'd0, 1'b0, 1'b0, 1'b1, 12'd1024});
    @(negedge clk);
    start1 = 1'b0;
    #1 chk("trace_T1", {38'd0, busy1, cs_a1, cs_b1, addr_a1, addr_b1},
           {38'd0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd257});
    @(negedge clk);
    #1 chk("trace_T2", {40'd0, addr_a1, addr_b1}, {40'd0, 12'd514, 12'd771});
    wait_drain(200);

    // Zero memory: output is the input halves swapped
    go1(32'h01234567, 32'h89ABCDEF, 1'b0, 64'h89ABCDEF_01234567);
    wait_drain(200);
    go1(32'h01234567, 32'h89ABCDEF, 1'b1, 64'h89ABCDEF_01234567);
    wait_drain(200);
    go2(32'h01234567, 32'h89ABCDEF, 1'b0, 64'h89ABCDEF_01234567);
    wait_drain(50);

    // start while busy is ignored
    d0 = done1_cnt;
    go1(32'h11111111, 32'h22222222, 1'b0, 64'h22222222_11111111);
    repeat (8) @(negedge clk);
    L1 = 32'hAAAAAAAA; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_drain(200);
    repeat (60) @(negedge clk);
    chk("one_done", 64'(done1_cnt - d0), 64'd1);

    // Reset mid-block aborts with no done
    go1(32'h33333333, 32'h44444444, 1'b0, 64'h44444444_33333333);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    exp1.delete();
    d0 = done1_cnt;
    @(negedge clk);
    chk("abort_flags", {60'd0, done1, busy1, cs_a1, cs_b1}, 64'b0011);
    chk("abort_result", result1, 64'd0);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("abort_no_done", 64'(done1_cnt - d0), 64'd0);
    go1(32'h55555555, 32'h66666666, 1'b0, 64'h66666666_55555555);
    wait_drain(200);

    // P[i] = i+1, S-boxes zero: F is 0, only P xors remain
    for (int i = 0; i < 18; i++) mem[PB + i] = 32'(i + 1);
    go1(32'h01234567, 32'h89ABCDEF, 1'b0, 64'h89ABCDED_01234576);
    wait_drain(200);
    go1(32'h89ABCDED, 32'h01234576, 1'b1, 64'h01234567_89ABCDEF);
    wait_drain(200);

    // Full pseudo-random tables: reference cipher and round trip
    for (int a = 0; a < 4096; a++) begin
      av = 32'(a);
      mem[a] = (av * 32'h9E3779B9) ^ (av << 13) ^ 32'h7F4A7C15;
    end
    for (int k = 0; k < 3; k++) begin
      e = bf_ref(vl[k], vr[k], 1'b0);
      go1(vl[k], vr[k], 1'b0, e);
      wait_drain(200);
      go1(e[63:32], e[31:0], 1'b1, {vl[k], vr[k]});
      wait_drain(200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
